// File: rtl/el2_exu_ffmul_ctl.sv
// ---------------------------------------------------------------------------
// el2_exu_ffmul_ctl
//
// Control and datapath for a GF(2^128) carry-less multiplier driven by
// custom instructions. The core loads two 128-bit operands (A and B) as
// 32-bit words. When both operands are complete, the block runs a bit-serial
// shift-and-add multiply with modular reduction, one bit of B per cycle.
// The 128-bit product is then read back one 32-bit word at a time.
//
// Ports
//   clk            core clock
//   rst            synchronous, active-high reset
//   custom_p       decoded custom op (load-start/load/load-end for A and B,
//                  ffmul1..4 word reads, valid qualifier)
//   custom_rs1     operand word for the load ops
//   flush          pipeline flush; cancels a pending read but not the multiply
//   ffmul_busy     multiply running, read pending, or writeback this cycle
//   ffmul_wb_valid one-cycle strobe for a result-word writeback
//   ffmul_wb_data  result word; zero when ffmul_wb_valid is low
//   ffmul_err      one-cycle pulse on any protocol violation
//   ffmul_done     a valid product is held
// ---------------------------------------------------------------------------

package el2_custom_pkg;
    typedef struct packed {
        logic valid;
        logic ffmul4;
        logic ffmul3;
        logic ffmul2;
        logic ffmul1;
        logic ffloadbe;
        logic ffloadb;
        logic ffloadbs;
        logic ffloadae;
        logic ffloada;
        logic ffloadas;
    } el2_custom_pkt_t;
endpackage

module el2_exu_ffmul_ctl
    import el2_custom_pkg::*;
#(
    parameter logic [127:0] POLY = 128'h87
) (
    input  logic            clk,
    input  logic            rst,
    input  el2_custom_pkt_t custom_p,
    input  logic [31:0]     custom_rs1,
    input  logic            flush,
    output logic            ffmul_busy,
    output logic            ffmul_wb_valid,
    output logic [31:0]     ffmul_wb_data,
    output logic            ffmul_err,
    output logic            ffmul_done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        WAIT_RD = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state;

    logic [3:0][31:0]  a_op;
    logic [3:0][31:0]  b_op;
    logic [2:0]        a_cnt;
    logic [2:0]        b_cnt;
    logic              a_cmp;
    logic              b_cmp;
    // Set when the held product belongs to the current operands, so a
    // finished multiply is not restarted just because both flags are still set.
    logic              prod_cur;

    logic [127:0]      z;
    logic [127:0]      v;
    logic [6:0]        cnt;
    logic [3:0][31:0]  result;

    logic              pend_valid;
    logic [1:0]        pend_idx;

    logic              done_r;
    logic              wb_valid_r;
    logic [31:0]       wb_data_r;
    logic              err_r;

    // Decode signals
    logic [9:0]        op_vec;
    logic              one_hot;
    logic              bad_op;
    logic              is_load;
    logic              is_read;
    logic [1:0]        rd_idx;
    logic              go_compute;
    logic              load_ok;
    logic              pend_after;
    logic              b_bit;
    logic [127:0]      z_step;
    logic [127:0]      v_step;

    always_comb begin
        op_vec = {custom_p.ffmul4, custom_p.ffmul3, custom_p.ffmul2, custom_p.ffmul1,
                  custom_p.ffloadbe, custom_p.ffloadb, custom_p.ffloadbs,
                  custom_p.ffloadae, custom_p.ffloada, custom_p.ffloadas};
        one_hot = custom_p.valid && (op_vec != 10'd0) && ((op_vec & (op_vec - 10'd1)) == 10'd0);
        bad_op  = custom_p.valid && !one_hot;
        is_load = one_hot && (op_vec[5:0] != 6'd0);
        is_read = one_hot && (op_vec[9:6] != 4'd0);

        rd_idx = 2'd0;
        if (custom_p.ffmul2) rd_idx = 2'd1;
        if (custom_p.ffmul3) rd_idx = 2'd2;
        if (custom_p.ffmul4) rd_idx = 2'd3;

        go_compute = ((state == IDLE) || (state == DONE)) && a_cmp && b_cmp && !prod_cur;
        // Operands are frozen while the multiply runs and also in the cycle
        // the multiply is being launched, since V captures A on that edge.
        load_ok    = ((state == IDLE) || (state == DONE)) && !go_compute;

        // A read issued on the completing edge still counts as pending; flush
        // always wins and drops whatever was pending.
        pend_after = !flush && (pend_valid || is_read);

        b_bit  = b_op[cnt[6:5]][cnt[4:0]];
        z_step = b_bit ? (z ^ v) : z;
        v_step = {v[126:0], 1'b0} ^ (v[127] ? POLY : 128'd0);
    end

    // Single sequential block: operand loading, the four-state FSM, the
    // bit-serial multiply and all registered outputs. Error and writeback
    // strobes default low each cycle so they form one-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a_op       <= '0;
            b_op       <= '0;
            a_cnt      <= '0;
            b_cnt      <= '0;
            a_cmp      <= 1'b0;
            b_cmp      <= 1'b0;
            prod_cur   <= 1'b0;
            z          <= '0;
            v          <= '0;
            cnt        <= '0;
            result     <= '0;
            pend_valid <= 1'b0;
            pend_idx   <= '0;
            done_r     <= 1'b0;
            wb_valid_r <= 1'b0;
            wb_data_r  <= '0;
            err_r      <= 1'b0;
        end else begin
            err_r      <= bad_op;
            wb_valid_r <= 1'b0;
            wb_data_r  <= '0;

            if (is_load) begin
                if (!load_ok) begin
                    err_r <= 1'b1;
                end else if (custom_p.ffloadas) begin
                    a_op     <= {96'd0, custom_rs1};
                    a_cnt    <= 3'd1;
                    a_cmp    <= 1'b0;
                    prod_cur <= 1'b0;
                end else if (custom_p.ffloada || custom_p.ffloadae) begin
                    if ((a_cnt == 3'd0) || (a_cnt == 3'd4)) begin
                        err_r <= 1'b1;
                    end else begin
                        a_op[a_cnt[1:0]] <= custom_rs1;
                        a_cnt            <= a_cnt + 3'd1;
                        prod_cur         <= 1'b0;
                        if (custom_p.ffloadae) a_cmp <= 1'b1;
                    end
                end else if (custom_p.ffloadbs) begin
                    b_op     <= {96'd0, custom_rs1};
                    b_cnt    <= 3'd1;
                    b_cmp    <= 1'b0;
                    prod_cur <= 1'b0;
                end else begin
                    if ((b_cnt == 3'd0) || (b_cnt == 3'd4)) begin
                        err_r <= 1'b1;
                    end else begin
                        b_op[b_cnt[1:0]] <= custom_rs1;
                        b_cnt            <= b_cnt + 3'd1;
                        prod_cur         <= 1'b0;
                        if (custom_p.ffloadbe) b_cmp <= 1'b1;
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (is_read) err_r <= 1'b1;
                end
                DONE: begin
                    // The held product stays readable until the next launch,
                    // including on the launch edge itself.
                    if (is_read) begin
                        wb_valid_r <= 1'b1;
                        wb_data_r  <= result[rd_idx];
                    end
                end
                COMPUTE: begin
                    z   <= z_step;
                    v   <= v_step;
                    cnt <= cnt + 7'd1;
                    if (is_read && pend_valid) err_r <= 1'b1;
                    if (is_read && !pend_valid) pend_idx <= rd_idx;
                    pend_valid <= pend_after;
                    if (cnt == 7'h7F) begin
                        result <= z_step;
                        done_r <= 1'b1;
                        state  <= pend_after ? WAIT_RD : DONE;
                    end
                end
                WAIT_RD: begin
                    if (is_read) err_r <= 1'b1;
                    if (!flush) begin
                        wb_valid_r <= 1'b1;
                        wb_data_r  <= result[pend_idx];
                    end
                    pend_valid <= 1'b0;
                    state      <= DONE;
                end
                default: state <= IDLE;
            endcase

            if (go_compute) begin
                state    <= COMPUTE;
                z        <= '0;
                v        <= a_op;
                cnt      <= '0;
                done_r   <= 1'b0;
                prod_cur <= 1'b1;
            end
        end
    end

    assign ffmul_busy     = (state == COMPUTE) || (state == WAIT_RD) || wb_valid_r;
    assign ffmul_wb_valid = wb_valid_r;
    assign ffmul_wb_data  = wb_data_r;
    assign ffmul_err      = err_r;
    assign ffmul_done     = done_r;

endmodule
